// File: rtl/sprite_pkg.sv
// Shared types and defaults for the sprite layers.
// Latency: n/a (types only).
// Backpressure: n/a.
package sprite_pkg;

  localparam int         CW_DEF     = 11;
  localparam logic [7:0] TRANSP_DEF = 8'hFF;

  // One pixel as it leaves the sprite layers: {R[2:0], G[2:0], B[1:0]}.
  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  // Screen coordinate at the default coordinate width.
  typedef logic [CW_DEF-1:0] coord_t;

endpackage

// File: rtl/sprite_addr_gen.sv
// Window compare plus multiplier-free sprite ROM address generator.
// Latency: in_win combinational from hc/vc; rom_addr registered, 1 cycle after hc/vc.
// Backpressure: none; one address per clock, never stalls.
// Ports: clk/rst_n; hc/vc scan coordinates; act_x/act_y active sprite origin;
//        enable gates the window (low until a frame has started); frame_start clears
//        the row accumulator; in_win stage-0 window flag; rom_addr registered address.
module sprite_addr_gen
  import sprite_pkg::*;
#(
  parameter int IMG_W = 360,
  parameter int IMG_H = 60,
  parameter int CW    = CW_DEF,
  parameter int AW    = $clog2(IMG_W*IMG_H)
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CW-1:0] hc,
  input  logic [CW-1:0] vc,
  input  logic [CW-1:0] act_x,
  input  logic [CW-1:0] act_y,
  input  logic          enable,
  input  logic          frame_start,
  output logic          in_win,
  output logic [AW-1:0] rom_addr
);

  localparam logic [CW:0] W_EXT = (CW+1)'(IMG_W);
  localparam logic [CW:0] H_EXT = (CW+1)'(IMG_H);

  // One extra bit so a sprite hanging off the right/bottom edge saturates
  // past the coordinate range instead of wrapping back to column/line 0.
  logic [CW:0]   hc_e, vc_e, x_lo, x_hi, x_last, y_lo, y_hi;
  logic [CW-1:0] col;
  logic [AW-1:0] row_base;

  assign hc_e   = {1'b0, hc};
  assign vc_e   = {1'b0, vc};
  assign x_lo   = {1'b0, act_x};
  assign y_lo   = {1'b0, act_y};
  assign x_hi   = x_lo + W_EXT;
  assign y_hi   = y_lo + H_EXT;
  assign x_last = x_hi - (CW+1)'(1);
  assign col    = hc - act_x;

  assign in_win = enable & (hc_e >= x_lo) & (hc_e < x_hi)
                         & (vc_e >= y_lo) & (vc_e < y_hi);

  // row_base holds (vc-act_y)*IMG_W; it steps by IMG_W after the last
  // column of each sprite line, so the address needs only an adder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_base <= '0;
      rom_addr <= '0;
    end else begin
      if (frame_start)
        row_base <= '0;
      else if (in_win && (hc_e == x_last))
        row_base <= row_base + AW'(IMG_W);
      rom_addr <= in_win ? (row_base + AW'(col)) : '0;
    end
  end

endmodule

// File: rtl/sprite_blitter.sv
// Movable sprite layer: ROM fetch, transparency key, tear-free position update.
// Latency: hc/vc to pix_rgb/pix_valid is ROM_LAT+2 cycles, fixed.
// Backpressure: none; free-running pixel pipeline with no stalls.
// Ports: clk, rst_n (async, active low); hc/vc scan position; frame_start pulse
//        before a frame's first pixel; pos_x_in/pos_y_in/pos_we shadow position write;
//        rom_addr/rom_data external synchronous ROM; pix_rgb/pix_valid output pixel.
// Optional build macro SPRITE_BLINK_EN adds BLINK_FRAMES and a blinking sprite.
module sprite_blitter
  import sprite_pkg::*;
#(
  parameter int         IMG_W        = 360,
  parameter int         IMG_H        = 60,
  parameter int         X0           = 140,
  parameter int         Y0           = 210,
  parameter int         CW           = CW_DEF,
  parameter int         ROM_LAT      = 1,
  parameter logic [7:0] TRANSP_KEY   = TRANSP_DEF,
`ifdef SPRITE_BLINK_EN
  parameter int         BLINK_FRAMES = 30,
`endif
  parameter int         AW           = $clog2(IMG_W*IMG_H)
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CW-1:0] hc,
  input  logic [CW-1:0] vc,
  input  logic          frame_start,
  input  logic [CW-1:0] pos_x_in,
  input  logic [CW-1:0] pos_y_in,
  input  logic          pos_we,
  output logic [AW-1:0] rom_addr,
  input  logic [7:0]    rom_data,
  output logic [7:0]    pix_rgb,
  output logic          pix_valid
);

  logic [CW-1:0] shadow_x, shadow_y, act_x, act_y;
  logic          armed;
  logic          in_win;
  logic          visible;
  logic [ROM_LAT:0] win_p;
  logic          win_d;
  logic          pix_vld_nxt;
  rgb332_t       pix_q;

  // Active position only moves on frame_start. armed stays low after reset
  // until a frame has properly begun, so a reset mid-frame cannot emit
  // pixels addressed from a row_base that missed the top of the sprite.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_x <= CW'(X0);
      shadow_y <= CW'(Y0);
      act_x    <= CW'(X0);
      act_y    <= CW'(Y0);
      armed    <= 1'b0;
    end else begin
      if (pos_we) begin
        shadow_x <= pos_x_in;
        shadow_y <= pos_y_in;
      end
      if (frame_start) begin
        act_x <= pos_we ? pos_x_in : shadow_x;
        act_y <= pos_we ? pos_y_in : shadow_y;
        armed <= 1'b1;
      end
    end
  end

`ifdef SPRITE_BLINK_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [BW-1:0] blink_cnt;

  // Frames are counted from the first frame_start after reset, so frames
  // 0..BLINK_FRAMES-1 are visible, the next BLINK_FRAMES hidden, and so on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      visible   <= 1'b1;
    end else if (frame_start && armed) begin
      if (blink_cnt == BW'(BLINK_FRAMES-1)) begin
        blink_cnt <= '0;
        visible   <= ~visible;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end
`else
  assign visible = 1'b1;
`endif

  sprite_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .CW    (CW),
    .AW    (AW)
  ) u_addr_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .hc          (hc),
    .vc          (vc),
    .act_x       (act_x),
    .act_y       (act_y),
    .enable      (armed),
    .frame_start (frame_start),
    .in_win      (in_win),
    .rom_addr    (rom_addr)
  );

  // Visibility is folded into the window flag at stage 0 so a hidden sprite
  // still drives addresses, and blink changes land exactly on frame edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      win_p <= '0;
    else
      win_p <= {win_p[ROM_LAT-1:0], in_win & visible};
  end

  assign win_d       = win_p[ROM_LAT];
  assign pix_vld_nxt = win_d & (rom_data != TRANSP_KEY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid <= 1'b0;
      pix_q     <= '0;
    end else begin
      pix_valid <= pix_vld_nxt;
      pix_q     <= pix_vld_nxt ? rgb332_t'(rom_data) : '0;
    end
  end

  assign pix_rgb = pix_q;

endmodule
